// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants and state encoding for the sprite engine
package sprite_pkg;

    localparam int SCREEN_W_DEF = 1024;
    localparam int SCREEN_H_DEF = 768;
    localparam int COLOR_W      = 24;

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_e;

    // Velocity reversal on a bounce; -8 has no positive twin so it becomes +7.
    function automatic logic signed [3:0] neg_vel(input logic signed [3:0] v);
        return (v == 4'sb1000) ? 4'sd7 : -v;
    endfunction

endpackage

// File: rtl/sprite_hit.sv
// rtl/sprite_hit.sv - coverage test of one square sprite against the current pixel
module sprite_hit #(
    parameter int SIZE = 64
) (
    input  logic        en_i,
    input  logic [10:0] x_i,
    input  logic [9:0]  y_i,
    input  logic [10:0] hcount_i,
    input  logic [9:0]  vcount_i,
    output logic        hit_o
);

    logic [11:0] x_end;
    logic [10:0] y_end;

    // One extra bit on the far edge so sprites near the top of the range never wrap.
    assign x_end = {1'b0, x_i} + 12'(SIZE);
    assign y_end = {1'b0, y_i} + 11'(SIZE);

    assign hit_o = en_i
                && (hcount_i >= x_i) && ({1'b0, hcount_i} < x_end)
                && (vcount_i >= y_i) && ({1'b0, vcount_i} < y_end);

endmodule

// File: rtl/sprite_engine.sv
// rtl/sprite_engine.sv - multi-sprite renderer with per-frame motion, bounce and collision flags
module sprite_engine
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int SIZE        = 64,
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF,
    // Sprite 0 occupies the low 24 bits.
    parameter logic [COLOR_W*NUM_SPRITES-1:0] COLORS =
        {24'hFF_FF_00, 24'h00_00_FF, 24'h00_FF_00, 24'hFF_00_FF},
    localparam int ID_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [10:0]            hcount,
    input  logic [9:0]             vcount,
    input  logic                   frame_start,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [ID_W-1:0]        cfg_id,
    input  logic [10:0]            cfg_x,
    input  logic [9:0]             cfg_y,
    input  logic signed [3:0]      cfg_vx,
    input  logic signed [3:0]      cfg_vy,
    input  logic                   cfg_en,
    output logic [COLOR_W-1:0]     pixel,
    output logic                   occupied,
    output logic [ID_W-1:0]        hit_id,
    output logic [NUM_SPRITES-1:0] collision,
    output logic                   collision_valid,
    output logic                   overrun
);

    localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - SIZE);
    localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - SIZE);

    state_e                state_q;
    logic [ID_W-1:0]       idx_q;
    logic                  overrun_q;
    logic [10:0]           x_q  [NUM_SPRITES];
    logic [9:0]            y_q  [NUM_SPRITES];
    logic signed [3:0]     vx_q [NUM_SPRITES];
    logic signed [3:0]     vy_q [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] en_q;

    logic [COLOR_W-1:0]     pixel_q;
    logic                   occupied_q;
    logic [ID_W-1:0]        hit_id_q;
    logic [NUM_SPRITES-1:0] collision_q;
    logic [NUM_SPRITES-1:0] coll_acc_q;
    logic                   collision_valid_q;

    logic                   cfg_id_ok;
    logic [10:0]            cur_x;
    logic [9:0]             cur_y;
    logic signed [3:0]      cur_vx;
    logic signed [3:0]      cur_vy;
    logic signed [11:0]     nx;
    logic signed [11:0]     ny;
    logic [10:0]            upd_x_d;
    logic [9:0]             upd_y_d;
    logic signed [3:0]      upd_vx_d;
    logic signed [3:0]      upd_vy_d;

    logic [NUM_SPRITES-1:0] hits;
    logic                   any_hit;
    logic                   multi_hit;
    logic [ID_W-1:0]        win_id;
    logic [COLOR_W-1:0]     win_color;

    assign cfg_ready = (state_q == IDLE) && !frame_start;
    assign cfg_id_ok = (int'(cfg_id) < NUM_SPRITES);

    // Motion step for the sprite currently selected by the update index.
    assign cur_x  = x_q[idx_q];
    assign cur_y  = y_q[idx_q];
    assign cur_vx = vx_q[idx_q];
    assign cur_vy = vy_q[idx_q];
    assign nx     = $signed({1'b0, cur_x}) + 12'(cur_vx);
    assign ny     = $signed({2'b00, cur_y}) + 12'(cur_vy);

    always_comb begin
        upd_x_d  = nx[10:0];
        upd_vx_d = cur_vx;
        if (nx[11]) begin
            upd_x_d  = '0;
            upd_vx_d = neg_vel(cur_vx);
        end else if (nx > X_MAX) begin
            upd_x_d  = X_MAX[10:0];
            upd_vx_d = neg_vel(cur_vx);
        end
    end

    always_comb begin
        upd_y_d  = ny[9:0];
        upd_vy_d = cur_vy;
        if (ny[11]) begin
            upd_y_d  = '0;
            upd_vy_d = neg_vel(cur_vy);
        end else if (ny > Y_MAX) begin
            upd_y_d  = Y_MAX[9:0];
            upd_vy_d = neg_vel(cur_vy);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            en_q      <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                x_q[i]  <= '0;
                y_q[i]  <= '0;
                vx_q[i] <= '0;
                vy_q[i] <= '0;
            end
        end else begin
            if (frame_start && state_q == UPDATE) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        state_q <= UPDATE;
                        idx_q   <= '0;
                    end else if (cfg_valid && cfg_id_ok) begin
                        x_q[cfg_id]  <= cfg_x;
                        y_q[cfg_id]  <= cfg_y;
                        vx_q[cfg_id] <= cfg_vx;
                        vy_q[cfg_id] <= cfg_vy;
                        en_q[cfg_id] <= cfg_en;
                    end
                end
                UPDATE: begin
                    if (en_q[idx_q]) begin
                        x_q[idx_q]  <= upd_x_d;
                        y_q[idx_q]  <= upd_y_d;
                        vx_q[idx_q] <= upd_vx_d;
                        vy_q[idx_q] <= upd_vy_d;
                    end
                    if (idx_q == ID_W'(NUM_SPRITES - 1)) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        sprite_hit #(
            .SIZE (SIZE)
        ) u_hit (
            .en_i     (en_q[g]),
            .x_i      (x_q[g]),
            .y_i      (y_q[g]),
            .hcount_i (hcount),
            .vcount_i (vcount),
            .hit_o    (hits[g])
        );
    end

    // Walk downwards so the lowest covering index is the one left standing.
    always_comb begin
        win_id    = '0;
        win_color = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hits[i]) begin
                win_id    = ID_W'(i);
                win_color = COLORS[i*COLOR_W +: COLOR_W];
            end
        end
    end

    assign any_hit   = |hits;
    assign multi_hit = |(hits & (hits - 1'b1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_q           <= '0;
            occupied_q        <= 1'b0;
            hit_id_q          <= '0;
            collision_q       <= '0;
            coll_acc_q        <= '0;
            collision_valid_q <= 1'b0;
        end else begin
            pixel_q           <= any_hit ? win_color : '0;
            occupied_q        <= any_hit;
            hit_id_q          <= any_hit ? win_id : '0;
            collision_valid_q <= frame_start;
            if (frame_start) begin
                collision_q <= coll_acc_q;
                coll_acc_q  <= multi_hit ? hits : '0;
            end else if (multi_hit) begin
                coll_acc_q <= coll_acc_q | hits;
            end
        end
    end

    assign pixel           = pixel_q;
    assign occupied        = occupied_q;
    assign hit_id          = hit_id_q;
    assign collision       = collision_q;
    assign collision_valid = collision_valid_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_sprite_engine.sv
// tb/tb_sprite_engine.sv - self-checking bench for sprite_engine with a behavioural sprite model
module tb_sprite_engine;

    localparam int NS = 4;
    localparam int SZ = 64;
    localparam int SW = 1024;
    localparam int SH = 768;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [10:0]       hcount;
    logic [9:0]        vcount;
    logic              frame_start;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_id;
    logic [10:0]       cfg_x;
    logic [9:0]        cfg_y;
    logic signed [3:0] cfg_vx;
    logic signed [3:0] cfg_vy;
    logic              cfg_en;
    logic [23:0]       pixel;
    logic              occupied;
    logic [1:0]        hit_id;
    logic [NS-1:0]     collision;
    logic              collision_valid;
    logic              overrun;

    int errors = 0;
    int checks = 0;

    int mx [NS];
    int my [NS];
    int mvx[NS];
    int mvy[NS];
    bit men[NS];
    int macc;
    logic [23:0] col_tab [NS] = '{24'hFF00FF, 24'h00FF00, 24'h0000FF, 24'hFFFF00};

    sprite_engine dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .hcount          (hcount),
        .vcount          (vcount),
        .frame_start     (frame_start),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_id          (cfg_id),
        .cfg_x           (cfg_x),
        .cfg_y           (cfg_y),
        .cfg_vx          (cfg_vx),
        .cfg_vy          (cfg_vy),
        .cfg_en          (cfg_en),
        .pixel           (pixel),
        .occupied        (occupied),
        .hit_id          (hit_id),
        .collision       (collision),
        .collision_valid (collision_valid),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int mneg(int v);
        return (v == -8) ? 7 : -v;
    endfunction

    function automatic bit mcov(int i, int h, int v);
        return men[i] && h >= mx[i] && h < mx[i] + SZ && v >= my[i] && v < my[i] + SZ;
    endfunction

    task automatic model_update();
        int n;
        for (int i = 0; i < NS; i++) begin
            if (men[i]) begin
                n = mx[i] + mvx[i];
                if (n < 0) begin mx[i] = 0; mvx[i] = mneg(mvx[i]); end
                else if (n > SW - SZ) begin mx[i] = SW - SZ; mvx[i] = mneg(mvx[i]); end
                else mx[i] = n;
                n = my[i] + mvy[i];
                if (n < 0) begin my[i] = 0; mvy[i] = mneg(mvy[i]); end
                else if (n > SH - SZ) begin my[i] = SH - SZ; mvy[i] = mneg(mvy[i]); end
                else my[i] = n;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic park();
        hcount = 11'd2000;
        vcount = 10'd1000;
    endtask

    task automatic probe(input int h, input int v);
        hcount = 11'(h);
        vcount = 10'(v);
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        frame_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_id = '0; cfg_x = '0; cfg_y = '0; cfg_vx = '0; cfg_vy = '0; cfg_en = 1'b0;
        park();
        for (int i = 0; i < NS; i++) begin
            mx[i] = 0; my[i] = 0; mvx[i] = 0; mvy[i] = 0; men[i] = 0;
        end
        macc = 0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic cfg_write(input int id, input int x, input int y, input int vx, input int vy, input bit en);
        cfg_id = 2'(id); cfg_x = 11'(x); cfg_y = 10'(y);
        cfg_vx = 4'(vx); cfg_vy = 4'(vy); cfg_en = en;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        mx[id] = x; my[id] = y; mvx[id] = vx; mvy[id] = vy; men[id] = en;
    endtask

    task automatic run_frame(output logic [NS-1:0] col, output logic cv);
        park();
        frame_start = 1'b1;
        tick();
        col = collision;
        cv = collision_valid;
        frame_start = 1'b0;
        repeat (NS) tick();
        model_update();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pixel !== 24'h0) begin errors++; $display("FAIL reset_pixel: got %h want 000000", pixel); end
        checks++; if (occupied !== 1'b0 || hit_id !== 2'd0) begin errors++; $display("FAIL reset_occ_id: got occ=%b id=%0d want 0/0", occupied, hit_id); end
        checks++; if (collision !== 4'b0 || collision_valid !== 1'b0) begin errors++; $display("FAIL reset_collision: got %b/%b want 0000/0", collision, collision_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
    endtask

    task automatic test_basic();
        do_reset();
        cfg_write(0, 100, 50, 0, 0, 1);
        probe(100, 50);
        checks++; if (pixel !== 24'hFF00FF) begin errors++; $display("FAIL basic_pixel: got %h want FF00FF", pixel); end
        checks++; if (occupied !== 1'b1 || hit_id !== 2'd0) begin errors++; $display("FAIL basic_occ: got occ=%b id=%0d want 1/0", occupied, hit_id); end
        probe(164, 50);
        checks++; if (occupied !== 1'b0 || pixel !== 24'h0) begin errors++; $display("FAIL basic_right_edge: got occ=%b pix=%h want 0/000000", occupied, pixel); end
        probe(163, 113);
        checks++; if (occupied !== 1'b1) begin errors++; $display("FAIL basic_corner: got %b want 1", occupied); end
        hcount = 11'd164;
        #1;
        checks++; if (occupied !== 1'b1) begin errors++; $display("FAIL basic_latency_hold: got %b want 1", occupied); end
        tick();
        checks++; if (occupied !== 1'b0) begin errors++; $display("FAIL basic_latency_update: got %b want 0", occupied); end
        probe(100, 114);
        checks++; if (occupied !== 1'b0) begin errors++; $display("FAIL basic_bottom_edge: got %b want 0", occupied); end
        probe(99, 50);
        checks++; if (occupied !== 1'b0) begin errors++; $display("FAIL basic_left_edge: got %b want 0", occupied); end
    endtask

    task automatic test_collision();
        int pulses;
        do_reset();
        cfg_write(0, 200, 200, 0, 0, 1);
        cfg_write(1, 200, 200, 0, 0, 1);
        probe(200, 200);
        checks++; if (pixel !== 24'hFF00FF || hit_id !== 2'd0) begin errors++; $display("FAIL coll_priority: got pix=%h id=%0d want FF00FF/0", pixel, hit_id); end
        park();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++; if (collision !== 4'b0011 || collision_valid !== 1'b1) begin errors++; $display("FAIL coll_flags: got %b/%b want 0011/1", collision, collision_valid); end
        pulses = 0;
        repeat (NS + 2) begin tick(); if (collision_valid) pulses++; end
        checks++; if (pulses != 0) begin errors++; $display("FAIL coll_single_pulse: got %0d extra pulses want 0", pulses); end
        hcount = 11'd210; vcount = 10'd210;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        park();
        repeat (NS) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++; if (collision !== 4'b0011) begin errors++; $display("FAIL coll_same_cycle: got %b want 0011", collision); end
        repeat (NS) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++; if (collision !== 4'b0000) begin errors++; $display("FAIL coll_cleared: got %b want 0000", collision); end
        repeat (NS) tick();
    endtask

    task automatic test_bounce();
        logic [NS-1:0] c;
        logic v;
        do_reset();
        cfg_write(2, 958, 300, 5, 0, 1);
        cfg_write(1, 3, 400, -8, 0, 1);
        run_frame(c, v);
        probe(959, 300);
        checks++; if (occupied !== 1'b0) begin errors++; $display("FAIL bounce_r1_out: got %b want 0", occupied); end
        probe(960, 300);
        checks++; if (occupied !== 1'b1 || hit_id !== 2'd2 || pixel !== 24'h0000FF) begin errors++; $display("FAIL bounce_r1_in: got occ=%b id=%0d pix=%h want 1/2/0000FF", occupied, hit_id, pixel); end
        probe(1024, 300);
        checks++; if (occupied !== 1'b0) begin errors++; $display("FAIL bounce_r1_far: got %b want 0", occupied); end
        probe(0, 400);
        checks++; if (occupied !== 1'b1 || hit_id !== 2'd1 || pixel !== 24'h00FF00) begin errors++; $display("FAIL bounce_l1: got occ=%b id=%0d pix=%h want 1/1/00FF00", occupied, hit_id, pixel); end
        run_frame(c, v);
        probe(954, 300);
        checks++; if (occupied !== 1'b0) begin errors++; $display("FAIL bounce_r2_out: got %b want 0", occupied); end
        probe(955, 300);
        checks++; if (occupied !== 1'b1) begin errors++; $display("FAIL bounce_r2_in: got %b want 1", occupied); end
        probe(6, 400);
        checks++; if (occupied !== 1'b0) begin errors++; $display("FAIL bounce_sat_out: got %b want 0", occupied); end
        probe(7, 400);
        checks++; if (occupied !== 1'b1) begin errors++; $display("FAIL bounce_sat_in: got %b want 1", occupied); end
    endtask

    task automatic test_cfg_stall();
        int low;
        do_reset();
        cfg_id = 2'd3; cfg_x = 11'd500; cfg_y = 10'd500; cfg_vx = 4'sd3; cfg_vy = 4'sd0; cfg_en = 1'b1;
        cfg_valid = 1'b1;
        frame_start = 1'b1;
        #1;
        low = 0;
        for (int k = 0; k < 20 && cfg_ready === 1'b0; k++) begin
            low++;
            @(posedge clk);
            #1;
            frame_start = 1'b0;
            #1;
        end
        checks++; if (low != NS + 1) begin errors++; $display("FAIL stall_cycles: got %0d want %0d", low, NS + 1); end
        tick();
        cfg_valid = 1'b0;
        probe(500, 500);
        checks++; if (occupied !== 1'b1 || hit_id !== 2'd3 || pixel !== 24'hFFFF00) begin errors++; $display("FAIL stall_write: got occ=%b id=%0d pix=%h want 1/3/FFFF00", occupied, hit_id, pixel); end
        probe(499, 500);
        checks++; if (occupied !== 1'b0) begin errors++; $display("FAIL stall_write_edge: got %b want 0", occupied); end
    endtask

    task automatic test_overrun();
        logic [NS-1:0] c;
        logic v;
        do_reset();
        cfg_write(0, 100, 100, 2, 0, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
        #1;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL overrun_busy: got %b want 0", cfg_ready); end
        repeat (2) tick();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL overrun_done: got %b want 1", cfg_ready); end
        model_update();
        probe(101, 100);
        checks++; if (occupied !== 1'b0) begin errors++; $display("FAIL overrun_single_step_out: got %b want 0", occupied); end
        probe(102, 100);
        checks++; if (occupied !== 1'b1) begin errors++; $display("FAIL overrun_single_step_in: got %b want 1", occupied); end
        run_frame(c, v);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cfg_write(0, 100, 50, 0, 0, 1);
        cfg_write(1, 100, 50, 1, 1, 1);
        hcount = 11'd100; vcount = 10'd50;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++; if (overrun !== 1'b1 || occupied !== 1'b1) begin errors++; $display("FAIL midreset_pre: got ovr=%b occ=%b want 1/1", overrun, occupied); end
        reset_n = 1'b0;
        #1;
        checks++; if (pixel !== 24'h0 || occupied !== 1'b0 || hit_id !== 2'd0) begin errors++; $display("FAIL midreset_render: got pix=%h occ=%b id=%0d want 0", pixel, occupied, hit_id); end
        checks++; if (collision !== 4'b0 || collision_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL midreset_flags: got col=%b cv=%b ovr=%b want 0", collision, collision_valid, overrun); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL midreset_idle: got %b want 1", cfg_ready); end
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        checks++; if (occupied !== 1'b0) begin errors++; $display("FAIL midreset_sprites: got %b want 0", occupied); end
    endtask

    task automatic test_random();
        logic [NS-1:0] c;
        logic v;
        int h, w, k, cnt, mask, eid;
        bit eocc;
        logic [23:0] epix;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < NS; i++) begin
                case (r)
                    0: cfg_write(i, int'($urandom_range(880, 1000)), int'($urandom_range(0, 100)),
                                 int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8, 1'b1);
                    1: cfg_write(i, int'($urandom_range(0, 120)), int'($urandom_range(650, 760)),
                                 int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8, 1'b1);
                    default: cfg_write(i, int'($urandom_range(0, 1000)), int'($urandom_range(0, 760)),
                                 int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                                 $urandom_range(0, 3) != 0);
                endcase
            end
            macc = 0;
            for (int f = 0; f < 5; f++) begin
                for (int p = 0; p < 12; p++) begin
                    k = int'($urandom_range(0, NS - 1));
                    h = mx[k] + int'($urandom_range(0, 79)) - 8;
                    w = my[k] + int'($urandom_range(0, 79)) - 8;
                    if (h < 0) h = 0;
                    if (w < 0) w = 0;
                    if (w > 1023) w = 1023;
                    eocc = 0; eid = 0; epix = 24'h0; cnt = 0; mask = 0;
                    for (int i = NS - 1; i >= 0; i--) begin
                        if (mcov(i, h, w)) begin
                            eocc = 1; eid = i; epix = col_tab[i]; cnt++; mask |= (1 << i);
                        end
                    end
                    if (cnt >= 2) macc |= mask;
                    probe(h, w);
                    checks++; if (occupied !== eocc) begin errors++; $display("FAIL rand_occ r%0d (%0d,%0d): got %b want %b", r, h, w, occupied, eocc); end
                    checks++; if (hit_id !== 2'(eid)) begin errors++; $display("FAIL rand_id r%0d (%0d,%0d): got %0d want %0d", r, h, w, hit_id, eid); end
                    checks++; if (pixel !== epix) begin errors++; $display("FAIL rand_pixel r%0d (%0d,%0d): got %h want %h", r, h, w, pixel, epix); end
                end
                run_frame(c, v);
                checks++; if (v !== 1'b1 || c !== NS'(macc)) begin errors++; $display("FAIL rand_collision r%0d f%0d: got %b/%b want %b/1", r, f, c, v, NS'(macc)); end
                macc = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_collision();
        test_bounce();
        test_cfg_stall();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
